data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

- Data-memory slave that answers the processor's data-memory port.
- Holds 2^N_ADDRESS words of storage:
  - combinational read to the CPU;
  - synchronous write from the CPU.
- A second valid/ready host port lets bench or board logic load operands and read results without hierarchical access.
- Captures 16-bit results when the CPU writes the result-high address.
- Sits between the processor data port and the system host logic, replacing the plain RAM model.

## Interface
- WIDTH, 8: data word width.
- N_ADDRESS, 8: address width; depth = 2^N_ADDRESS.
- RESULT_LO_ADDR, 8'h02: address of the result low byte.
- RESULT_HI_ADDR, 8'h03: address of the result high byte; a CPU write here triggers capture.
- Ports:
  - _iClk  in  1  sole clock; everything is rising-edge.
  - _iReset  in  1  reset; asynchronous, active-low.
  - _iDataMemAddr  in  N_ADDRESS  CPU data address.
  - _iDataMemWData  in  WIDTH  CPU write data.
  - _iDataMemWrite  in  1  CPU write enable.
  - _oDataMemRData  out  WIDTH  CPU read data; combinational from the addressed word.
  - _iHostValid  in  1  host request valid.
  - _oHostReady  out  1  host request accepted this edge when both Valid and Ready are high.
  - _iHostWrite  in  1  1 = write request, 0 = read request.
  - _iHostAddr  in  N_ADDRESS  host address.
  - _iHostWData  in  WIDTH  host write data.
  - _oHostRData  out  WIDTH  read data, or write-back data for writes.
  - _oHostRValid  out  1  one-cycle response strobe.
  - _oResult  out  2*WIDTH  last captured {hi, lo}.
  - _oResultValid  out  1  one-cycle capture pulse.
  - _oResultCount  out  16  number of captures; saturating.

## Operation
- **Reset** (_iReset low, asynchronous): all storage words = 0, FSM = IDLE.
  - Outputs: _oHostRData=0, _oHostRValid=0, _oResult=0, _oResultValid=0, _oResultCount=0.
  - _oHostReady=0 while reset is asserted.
- **CPU path:**
  - _oDataMemRData = mem[_iDataMemAddr] with no clock.
  - When _iDataMemWrite=1, mem[_iDataMemAddr] <= _iDataMemWData at the edge.
  - The CPU always has priority and is never stalled.
- **Host FSM** (states IDLE, ACCESS, RESP):
  - IDLE: _oHostReady = !_iDataMemWrite. On Valid&&Ready, latch write/addr/wdata and go to ACCESS.
  - ACCESS:
    - If _iDataMemWrite=1 this cycle, stay in ACCESS (stall).
    - Otherwise perform the access at the edge and go to RESP:
      - write: mem[addr] <= wdata, _oHostRData <= wdata;
      - read: _oHostRData <= mem[addr].
  - RESP: _oHostRValid=1 for exactly one cycle, then return to IDLE.
  - _oHostRData holds its value until the next response.
- **Result capture:** on a CPU write to RESULT_HI_ADDR:
  - _oResult <= {_iDataMemWData, mem[RESULT_LO_ADDR]};
  - _oResultValid pulses for one cycle;
  - _oResultCount increments and saturates at 16'hFFFF.
- **Address width:** host and CPU addresses are used modulo 2^N_ADDRESS; there is no out-of-range case.

## Timing
- CPU read: zero-cycle latency. A CPU write is visible on _oDataMemRData the cycle after its edge.
- Host request, uncontended:
  - accepted at edge E0;
  - access at E1, with _oHostRValid high during E1→E2;
  - FSM back in IDLE after E2;
  - next acceptance no earlier than E3 (throughput 1 request per 3 cycles).
- Each cycle the CPU writes during ACCESS adds one cycle of latency. There is no starvation limit; host traffic waits.
- Host read stalled behind a CPU write to the same address returns the CPU's new data.
- _oResultValid is high in the cycle after the capturing edge; back-to-back captures produce consecutive pulses.
- Reset mid-ACCESS or mid-RESP: the request is dropped, no RValid is issued, and the stored host write is not performed.

## Configuration
- DMEM_RESULT_CAPTURE_EN defined: result capture logic is present as described.
- Not defined: _oResult, _oResultValid and _oResultCount are tied to 0, and no capture registers are synthesized.
- Storage and host behaviour are identical in both builds.

## Structure
- Package dmem_pkg holds:
  - host_state_e {IDLE, ACCESS, RESP};
  - RESULT_COUNT_W = 16;
  - default RESULT_LO_ADDR / RESULT_HI_ADDR constants.
- One sub-module, dmem_result_capture:
  - inputs: CPU write strobe, address, data, and the lo word;
  - holds the capture register, pulse and saturating counter;
  - instantiated only under DMEM_RESULT_CAPTURE_EN.

## Test plan
- Reset, then CPU reads address 8'h10 → _oDataMemRData=0. All outputs are 0 during reset.
- CPU writes 8'hA5 to 8'h10, then host reads 8'h10 → _oHostRValid one cycle, _oHostRData=8'hA5 at E1.
- Host writes 8'h3C to 8'h20 while the CPU writes on 4 consecutive cycles:
  - _oHostReady stays low until the writes end;
  - RValid comes 4 cycles late;
  - CPU then reads 8'h3C from 8'h20.
- CPU writes 8'h34 to 8'h02, then 8'h12 to 8'h03 → _oResult=16'h1234, one _oResultValid pulse, _oResultCount=1.
- Same sequence with DMEM_RESULT_CAPTURE_EN undefined → _oResult=0, no pulse, count=0.
- Host write in ACCESS when _iReset is pulsed low → no RValid; target word reads 0 after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } host_state_e;

  localparam int RESULT_COUNT_W = 16;

  localparam logic [7:0] DEFAULT_RESULT_LO_ADDR = 8'h02;
  localparam logic [7:0] DEFAULT_RESULT_HI_ADDR = 8'h03;

endpackage

// File: rtl/data_mem_responder_if.sv
// Bundle of the CPU data port, the host request port, the result outputs
// and the host FSM state for the data-memory responder.
interface data_mem_responder_if
  import dmem_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_ADDRESS = 8
) ();

  // CPU data port: combinational read, write committed at the rising edge.
  logic [N_ADDRESS-1:0]      data_mem_addr;
  logic [WIDTH-1:0]          data_mem_wdata;
  logic                      data_mem_write;
  logic [WIDTH-1:0]          data_mem_rdata;

  // Host port: a request transfers at a rising edge where host_valid and
  // host_ready are both high; the requester holds addr/wdata/write stable
  // while host_valid is high. Each transfer yields exactly one host_rvalid
  // strobe, during which host_rdata carries the read or written word.
  logic                      host_valid;
  logic                      host_ready;
  logic                      host_write;
  logic [N_ADDRESS-1:0]      host_addr;
  logic [WIDTH-1:0]          host_wdata;
  logic [WIDTH-1:0]          host_rdata;
  logic                      host_rvalid;

  logic [2*WIDTH-1:0]        result;
  logic                      result_valid;
  logic [RESULT_COUNT_W-1:0] result_count;

  host_state_e               host_state;

  modport master (
    output data_mem_addr, data_mem_wdata, data_mem_write,
    input  data_mem_rdata,
    output host_valid, host_write, host_addr, host_wdata,
    input  host_ready, host_rdata, host_rvalid,
    input  result, result_valid, result_count,
    input  host_state
  );

  modport slave (
    input  data_mem_addr, data_mem_wdata, data_mem_write,
    output data_mem_rdata,
    input  host_valid, host_write, host_addr, host_wdata,
    output host_ready, host_rdata, host_rvalid,
    output result, result_valid, result_count,
    output host_state
  );

endinterface

// File: rtl/dmem_result_capture.sv
// Captures {hi, lo} whenever the CPU writes the result-high address, with a
// one-cycle pulse and a saturating capture counter.
module dmem_result_capture
  import dmem_pkg::*;
#(
  parameter int                   WIDTH          = 8,
  parameter int                   N_ADDRESS      = 8,
  parameter logic [N_ADDRESS-1:0] RESULT_HI_ADDR = DEFAULT_RESULT_HI_ADDR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_write,
  input  logic [N_ADDRESS-1:0]      cpu_addr,
  input  logic [WIDTH-1:0]          cpu_wdata,
  input  logic [WIDTH-1:0]          lo_word,
  output logic [2*WIDTH-1:0]        result,
  output logic                      result_valid,
  output logic [RESULT_COUNT_W-1:0] result_count
);

  logic capture;

  assign capture = cpu_write && (cpu_addr == RESULT_HI_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
      result_count <= '0;
    end else begin
      result_valid <= capture;
      if (capture) begin
        result <= {cpu_wdata, lo_word};
        if (result_count != {RESULT_COUNT_W{1'b1}}) begin
          result_count <= result_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave: CPU port with priority plus a valid/ready host port.
// Result capture is built only when DMEM_RESULT_CAPTURE_EN is defined.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int                   WIDTH          = 8,
  parameter int                   N_ADDRESS      = 8,
  parameter logic [N_ADDRESS-1:0] RESULT_LO_ADDR = DEFAULT_RESULT_LO_ADDR,
  parameter logic [N_ADDRESS-1:0] RESULT_HI_ADDR = DEFAULT_RESULT_HI_ADDR
) (
  input  logic                _iClk,
  input  logic                _iReset,
  data_mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << N_ADDRESS;

  logic [WIDTH-1:0]     mem [DEPTH];

  host_state_e          state_q;
  host_state_e          state_d;
  logic                 req_write_q;
  logic [N_ADDRESS-1:0] req_addr_q;
  logic [WIDTH-1:0]     req_wdata_q;
  logic [WIDTH-1:0]     host_rdata_q;
  logic                 accept;
  logic                 do_access;

  assign bus.data_mem_rdata = mem[bus.data_mem_addr];
  assign bus.host_rdata     = host_rdata_q;
  assign bus.host_state     = state_q;

  // Any CPU write blocks the host, both at acceptance and at the access itself.
  always_comb begin
    state_d         = state_q;
    bus.host_ready  = 1'b0;
    bus.host_rvalid = 1'b0;
    accept          = 1'b0;
    do_access       = 1'b0;
    case (state_q)
      IDLE: begin
        bus.host_ready = _iReset && !bus.data_mem_write;
        accept         = bus.host_valid && bus.host_ready;
        if (accept) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.data_mem_write) begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        bus.host_rvalid = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge _iClk or negedge _iReset) begin
    if (!_iReset) begin
      state_q      <= IDLE;
      req_write_q  <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_write_q <= bus.host_write;
        req_addr_q  <= bus.host_addr;
        req_wdata_q <= bus.host_wdata;
      end
      if (do_access) begin
        host_rdata_q <= req_write_q ? req_wdata_q : mem[req_addr_q];
      end
    end
  end

  // do_access is only high when the CPU is not writing, so the two write
  // ports never collide.
  always_ff @(posedge _iClk or negedge _iReset) begin
    if (!_iReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.data_mem_write) begin
      mem[bus.data_mem_addr] <= bus.data_mem_wdata;
    end else if (do_access && req_write_q) begin
      mem[req_addr_q] <= req_wdata_q;
    end
  end

`ifdef DMEM_RESULT_CAPTURE_EN
  dmem_result_capture #(
    .WIDTH          (WIDTH),
    .N_ADDRESS      (N_ADDRESS),
    .RESULT_HI_ADDR (RESULT_HI_ADDR)
  ) u_result_capture (
    .clk          (_iClk),
    .rst_n        (_iReset),
    .cpu_write    (bus.data_mem_write),
    .cpu_addr     (bus.data_mem_addr),
    .cpu_wdata    (bus.data_mem_wdata),
    .lo_word      (mem[RESULT_LO_ADDR]),
    .result       (bus.result),
    .result_valid (bus.result_valid),
    .result_count (bus.result_count)
  );
`else
  assign bus.result       = '0;
  assign bus.result_valid = 1'b0;
  assign bus.result_count = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: host responses go through an
// expected queue; CPU reads and result outputs are checked against a model.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int WIDTH     = 8;
  localparam int N_ADDRESS = 8;

`ifdef DMEM_RESULT_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk;
  logic rst_n;

  data_mem_responder_if #(.WIDTH(WIDTH), .N_ADDRESS(N_ADDRESS)) bus ();

  data_mem_responder #(
    .WIDTH     (WIDTH),
    .N_ADDRESS (N_ADDRESS)
  ) dut (
    ._iClk   (clk),
    ._iReset (rst_n),
    .bus     (bus)
  );

  int               assertions;
  int               failures;
  int               result_pulses;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_mem [256];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.host_rvalid) begin
      if (exp_q.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
      else check("host_rdata", 32'(bus.host_rdata), 32'(exp_q.pop_front()));
    end
    if (rst_n && bus.result_valid) result_pulses++;
  end

  // ---------------- drivers ----------------
  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
    bus.data_mem_addr  = addr;
    bus.data_mem_wdata = data;
    bus.data_mem_write = 1'b1;
    @(posedge clk);
    model_mem[addr] = data;
    #1;
    bus.data_mem_write = 1'b0;
  endtask

  task automatic host_req(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp, input bit push, output int waits);
    bit accepted;
    accepted        = 1'b0;
    waits           = 0;
    bus.host_write  = wr;
    bus.host_addr   = addr;
    bus.host_wdata  = wdata;
    bus.host_valid  = 1'b1;
    for (int i = 0; i < 64 && !accepted; i++) begin
      @(negedge clk);
      if (bus.host_ready) begin
        @(posedge clk);
        #1;
        bus.host_valid = 1'b0;
        accepted       = 1'b1;
        if (push) begin
          exp_q.push_back(exp);
          if (wr) model_mem[addr] = wdata;
        end
      end else begin
        waits++;
      end
    end
    if (!accepted) begin
      check("host_accept_timeout", 32'd0, 32'd1);
      bus.host_valid = 1'b0;
    end
  endtask

  // Counts negedges from the acceptance edge to the response strobe.
  task automatic wait_rvalid(output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.host_rvalid) got = 1'b1;
      else check("busy_ready", 32'(bus.host_ready), 32'd0);
    end
    if (!got) begin
      check("rvalid_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check("rvalid_one_cycle", 32'(bus.host_rvalid), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waits;
    int lat;
    logic [7:0] a;
    logic [7:0] d;
    logic       w;

    assertions         = 0;
    failures           = 0;
    result_pulses      = 0;
    rst_n              = 1'b0;
    bus.data_mem_addr  = 8'h10;
    bus.data_mem_wdata = '0;
    bus.data_mem_write = 1'b0;
    bus.host_valid     = 1'b0;
    bus.host_write     = 1'b0;
    bus.host_addr      = '0;
    bus.host_wdata     = '0;
    foreach (model_mem[i]) model_mem[i] = '0;

    #12;
    check("rst_host_ready",   32'(bus.host_ready),     32'd0);
    check("rst_host_rvalid",  32'(bus.host_rvalid),    32'd0);
    check("rst_host_rdata",   32'(bus.host_rdata),     32'd0);
    check("rst_result",       32'(bus.result),         32'd0);
    check("rst_result_valid", 32'(bus.result_valid),   32'd0);
    check("rst_result_count", 32'(bus.result_count),   32'd0);
    check("rst_cpu_rdata",    32'(bus.data_mem_rdata), 32'd0);
    check("rst_state",        32'(bus.host_state),     32'(IDLE));

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(bus.host_ready), 32'd1);

    // CPU write then uncontended host read
    cpu_write(8'h10, 8'hA5);
    check("cpu_readback_10", 32'(bus.data_mem_rdata), 32'hA5);
    host_req(1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, waits);
    check("read_accept_wait", waits, 0);
    wait_rvalid(lat);
    check("read_latency", lat, 2);

    // Host write blocked at acceptance by 4 consecutive CPU writes
    fork
      begin
        for (int i = 0; i < 4; i++) cpu_write(8'h40 + 8'(i), 8'($urandom_range(0, 255)));
      end
      host_req(1'b1, 8'h20, 8'h3C, 8'h3C, 1'b1, waits);
    join
    check("contended_accept_wait", waits, 4);
    wait_rvalid(lat);
    check("contended_latency", lat, 2);
    bus.data_mem_addr = 8'h20;
    #1;
    check("cpu_reads_host_write", 32'(bus.data_mem_rdata), 32'h3C);

    // Host read stalled in ACCESS behind a CPU write to the same address
    host_req(1'b0, 8'h50, 8'h00, 8'h77, 1'b1, waits);
    fork
      begin
        cpu_write(8'h50, 8'h77);
        cpu_write(8'h51, 8'h11);
        cpu_write(8'h52, 8'h22);
      end
      wait_rvalid(lat);
    join
    check("stalled_latency", lat, 5);

    // Random back-to-back host traffic, then CPU-side readback
    for (int n = 0; n < 10; n++) begin
      a = 8'($urandom_range(128, 255));
      d = 8'($urandom_range(0, 255));
      w = 1'($urandom_range(0, 1));
      host_req(w, a, d, w ? d : model_mem[a], 1'b1, waits);
      check("b2b_accept_wait", waits, 0);
      wait_rvalid(lat);
      check("b2b_latency", lat, 2);
      bus.data_mem_addr = a;
      #1;
      check("cpu_readback_rand", 32'(bus.data_mem_rdata), 32'(model_mem[a]));
    end

    // Result capture
    result_pulses = 0;
    cpu_write(8'h02, 8'h34);
    cpu_write(8'h03, 8'h12);
    @(negedge clk);
    check("result_first",       32'(bus.result),       CAP ? 32'h1234 : 32'd0);
    check("result_valid_pulse", 32'(bus.result_valid), 32'(CAP));
    check("result_count_1",     32'(bus.result_count), CAP ? 32'd1 : 32'd0);
    @(negedge clk);
    check("result_valid_drop",  32'(bus.result_valid), 32'd0);
    @(posedge clk);
    #1;
    cpu_write(8'h03, 8'h56);
    cpu_write(8'h03, 8'h78);
    @(negedge clk);
    check("result_last",        32'(bus.result),       CAP ? 32'h7834 : 32'd0);
    check("result_count_3",     32'(bus.result_count), CAP ? 32'd3 : 32'd0);
    @(negedge clk);
    #1;
    check("result_pulses",      result_pulses,         CAP ? 3 : 0);
    @(posedge clk);
    #1;

    // Reset while a host write sits in ACCESS
    host_req(1'b1, 8'h60, 8'h99, 8'h00, 1'b0, waits);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready",        32'(bus.host_ready),   32'd0);
    check("midrst_rvalid",       32'(bus.host_rvalid),  32'd0);
    check("midrst_state",        32'(bus.host_state),   32'(IDLE));
    check("midrst_host_rdata",   32'(bus.host_rdata),   32'd0);
    check("midrst_result_count", 32'(bus.result_count), 32'd0);
    check("midrst_result",       32'(bus.result),       32'd0);
    foreach (model_mem[i]) model_mem[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.data_mem_addr = 8'h60;
    #1;
    check("dropped_write_word", 32'(bus.data_mem_rdata), 32'd0);
    bus.data_mem_addr = 8'h10;
    #1;
    check("cleared_word_10", 32'(bus.data_mem_rdata), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    host_req(1'b0, 8'h60, 8'h00, 8'h00, 1'b1, waits);
    wait_rvalid(lat);
    check("post_reset_latency", lat, 2);
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
